// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled asynchronous serial receiver.
// The line is synchronized, a falling edge starts a frame, the start bit is
// re-checked at its centre, data bits are sampled at the last tick of each bit
// period, and the stop-bit sample publishes the byte and its status flags.
module uart_rx #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned OVS       = 16
) (
   input  logic       bclk,
   input  logic       rst_n,
   input  logic       rxd,
   input  logic       rxd_ack,
   output logic [7:0] rx_data,
   output logic       rxd_readyH,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] TCT_MID  = CW'(OVS / 2 - 1);
   localparam logic [CW-1:0] TCT_END  = CW'(OVS - 1);
   localparam logic [CW-1:0] BCT_LAST = CW'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t                 state;
   logic [CW-1:0]          tct;
   logic [CW-1:0]          bct;
   logic [DATA_BITS-1:0]   shreg;
   logic                   sync1;
   logic                   rxs;
   logic                   rxs_d;
   logic                   start_edge_c;
   logic                   stop_sample_c;

   // Two-flop synchronizer plus previous-value flop; idle level is high.
   always_ff @(posedge bclk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
         rxs_d <= 1'b1;
      end else begin
         sync1 <= rxd;
         rxs   <= sync1;
         rxs_d <= rxs;
      end
   end

   // Only a fresh high-to-low transition may start a frame.
   assign start_edge_c  = rxs_d & ~rxs;
   assign stop_sample_c = (state == STOP) && (tct == TCT_END);

   // Frame sequencer: tick/bit counters, shift register and registered busy.
   always_ff @(posedge bclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         tct   <= '0;
         bct   <= '0;
         shreg <= '0;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_edge_c) begin
                  state <= START;
                  tct   <= '0;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (tct == TCT_MID) begin
                  tct <= '0;
                  if (!rxs) begin
                     state <= DATA;
                     bct   <= '0;
                  end else begin
                     // Start bit gone by mid-bit: treat as a glitch.
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  tct <= tct + CW'(1);
               end
            end
            DATA: begin
               if (tct == TCT_END) begin
                  tct   <= '0;
                  shreg <= {rxs, shreg[DATA_BITS-1:1]};
                  bct   <= bct + CW'(1);
                  if (bct == BCT_LAST) begin
                     state <= STOP;
                  end
               end else begin
                  tct <= tct + CW'(1);
               end
            end
            STOP: begin
               if (tct == TCT_END) begin
                  tct   <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  tct <= tct + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               tct   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Output byte and status flags; a stop sample outranks a same-cycle ack.
   always_ff @(posedge bclk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data    <= '0;
         rxd_readyH <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else if (stop_sample_c) begin
         rx_data    <= 8'(shreg);
         rxd_readyH <= 1'b1;
         frame_err  <= ~rxs;
         if (rxd_readyH && !rxd_ack) begin
            overrun <= 1'b1;
         end
      end else if (rxd_ack) begin
         rxd_readyH <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx at default parameters.
module tb_uart_rx;

   logic       bclk = 1'b0;
   logic       rst_n;
   logic       rxd;
   logic       rxd_ack;
   logic [7:0] rx_data;
   logic       rxd_readyH;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_t0  = 0;
   int rise_cnt = 0;
   int rise_cyc = 0;
   int r0;
   logic ready_q = 1'b0;

   uart_rx dut (
      .bclk       (bclk),
      .rst_n      (rst_n),
      .rxd        (rxd),
      .rxd_ack    (rxd_ack),
      .rx_data    (rx_data),
      .rxd_readyH (rxd_readyH),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 bclk = ~bclk;

   // Free-running posedge count used as the time base.
   always @(posedge bclk) cyc <= cyc + 1;

   // Records each rising edge of rxd_readyH.
   always @(negedge bclk) begin
      if (rxd_readyH && !ready_q) begin
         rise_cnt <= rise_cnt + 1;
         rise_cyc <= cyc;
      end
      ready_q <= rxd_readyH;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Drives one frame, 16 negedges per bit; optional ack pulse at step ack_step.
   task automatic send_frame(input logic [7:0] d, input logic stop_b,
                             input int ack_step, input int n_steps);
      int bi;
      for (int i = 0; i < n_steps; i++) begin
         @(negedge bclk);
         if (i == 0) last_t0 = cyc;
         bi = i / 16;
         if (bi == 0)      rxd = 1'b0;
         else if (bi == 9) rxd = stop_b;
         else              rxd = d[bi-1];
         rxd_ack = (i == ack_step);
      end
      rxd_ack = 1'b0;
   endtask

   task automatic pulse_ack();
      @(negedge bclk);
      rxd_ack = 1'b1;
      @(negedge bclk);
      rxd_ack = 1'b0;
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge bclk);
   endtask

   initial begin
      rxd     = 1'b1;
      rxd_ack = 1'b0;
      rst_n   = 1'b0;
      repeat (3) @(negedge bclk);
      check("rst_data",  32'(rx_data), 32'h00);
      check("rst_ready", 32'(rxd_readyH), 32'd0);
      check("rst_ferr",  32'(frame_err), 32'd0);
      check("rst_ovr",   32'(overrun), 32'd0);
      check("rst_busy",  32'(busy), 32'd0);
      rst_n = 1'b1;
      idle(5);

      // 0xA5: ready rises 152 cycles after detect, detect is 3 edges after the fall.
      send_frame(8'hA5, 1'b1, -1, 160);
      check("a5_latency", 32'(rise_cyc - last_t0), 32'd155);
      check("a5_data",    32'(rx_data), 32'hA5);
      check("a5_ready",   32'(rxd_readyH), 32'd1);
      check("a5_ferr",    32'(frame_err), 32'd0);
      check("a5_ovr",     32'(overrun), 32'd0);
      check("a5_busy",    32'(busy), 32'd0);
      pulse_ack();
      check("a5_ack_ready", 32'(rxd_readyH), 32'd0);
      check("a5_ack_data",  32'(rx_data), 32'hA5);

      // 5-tick glitch: enters START, abandons it at the mid-bit check.
      @(negedge bclk);
      rxd = 1'b0;
      repeat (5) @(negedge bclk);
      rxd = 1'b1;
      check("glitch_busy_hi", 32'(busy), 32'd1);
      repeat (20) @(negedge bclk);
      check("glitch_busy_lo", 32'(busy), 32'd0);
      check("glitch_ready",   32'(rxd_readyH), 32'd0);
      check("glitch_data",    32'(rx_data), 32'hA5);

      // 0x3C with a bad stop bit.
      send_frame(8'h3C, 1'b0, -1, 160);
      idle(20);
      check("3c_ready", 32'(rxd_readyH), 32'd1);
      check("3c_ferr",  32'(frame_err), 32'd1);
      check("3c_data",  32'(rx_data), 32'h3C);
      check("3c_ovr",   32'(overrun), 32'd0);
      pulse_ack();
      check("3c_ack_ready", 32'(rxd_readyH), 32'd0);
      check("3c_ack_ferr",  32'(frame_err), 32'd0);
      check("3c_ack_ovr",   32'(overrun), 32'd0);
      idle(10);

      // Back-to-back without ack: overrun.
      send_frame(8'h11, 1'b1, -1, 160);
      check("b2b_first_data", 32'(rx_data), 32'h11);
      check("b2b_first_ovr",  32'(overrun), 32'd0);
      send_frame(8'h22, 1'b1, -1, 160);
      check("b2b_data",  32'(rx_data), 32'h22);
      check("b2b_ovr",   32'(overrun), 32'd1);
      check("b2b_ready", 32'(rxd_readyH), 32'd1);
      pulse_ack();
      check("b2b_ack_ovr", 32'(overrun), 32'd0);
      idle(10);

      // Back-to-back with ack coincident with the second stop sample.
      send_frame(8'h11, 1'b1, -1, 160);
      send_frame(8'h22, 1'b1, 154, 160);
      check("ackstop_data",  32'(rx_data), 32'h22);
      check("ackstop_ovr",   32'(overrun), 32'd0);
      check("ackstop_ready", 32'(rxd_readyH), 32'd1);
      check("ackstop_ferr",  32'(frame_err), 32'd0);

      // Reset in the middle of the data bits.
      send_frame(8'h00, 1'b1, -1, 60);
      check("mid_busy", 32'(busy), 32'd1);
      rxd   = 1'b1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_data",  32'(rx_data), 32'h00);
      check("mid_rst_ready", 32'(rxd_readyH), 32'd0);
      check("mid_rst_busy",  32'(busy), 32'd0);
      check("mid_rst_ovr",   32'(overrun), 32'd0);
      repeat (3) @(negedge bclk);
      rst_n = 1'b1;
      idle(5);
      send_frame(8'h5A, 1'b1, -1, 160);
      check("5a_latency", 32'(rise_cyc - last_t0), 32'd155);
      check("5a_data",    32'(rx_data), 32'h5A);
      check("5a_ready",   32'(rxd_readyH), 32'd1);
      check("5a_ferr",    32'(frame_err), 32'd0);
      pulse_ack();
      idle(10);

      // Bad stop then line held low for three frame times: single frame only.
      r0 = rise_cnt;
      send_frame(8'h81, 1'b0, -1, 160);
      repeat (480) @(negedge bclk);
      check("low_rises", 32'(rise_cnt - r0), 32'd1);
      check("low_ferr",  32'(frame_err), 32'd1);
      check("low_data",  32'(rx_data), 32'h81);
      check("low_busy",  32'(busy), 32'd0);
      pulse_ack();
      repeat (20) @(negedge bclk);
      check("low_ack_ready", 32'(rxd_readyH), 32'd0);
      check("low_ack_busy",  32'(busy), 32'd0);
      idle(20);
      send_frame(8'h42, 1'b1, -1, 160);
      check("42_data",  32'(rx_data), 32'h42);
      check("42_ferr",  32'(frame_err), 32'd0);
      check("42_ready", 32'(rxd_readyH), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning data bits per frame (legal range 5..8).
REQ-002 Parameter OVS, default 16, meaning bclk ticks per serial bit (16x oversampling).
REQ-003 bclk  input  1  bit-rate x16 clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rxd  input  1  asynchronous serial line; idles high.
REQ-006 rxd_ack  input  1  consumer acknowledge; clears rxd_readyH, frame_err and overrun.
REQ-007 rx_data  output  8  received byte, LSB = first bit; unused upper bits 0 when DATA_BITS<8.
REQ-008 rxd_readyH  output  1  high when rx_data holds an unacknowledged frame.
REQ-009 frame_err  output  1  the last completed frame had stop bit = 0.
REQ-010 overrun  output  1  a frame completed while rxd_readyH was still set.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer; both flops reset to 1; all logic uses the synchronized value rxs.
REQ-013 A previous-value flop rxs_d SHALL be kept; a start edge is rxs_d=1 and rxs=0.
REQ-014 FSM states: IDLE, START, DATA, STOP; 4-bit tick counter tct; 4-bit bit counter bct.
REQ-015 IDLE: on a start edge -> START with tct cleared to 0; a line held low without a fresh edge SHALL NOT trigger.
REQ-016 START: tct increments each cycle; at tct=OVS/2-1, rxs=0 -> DATA with tct=0 and bct=0; rxs=1 -> IDLE (false start, no outputs change).
REQ-017 DATA: tct increments each cycle and wraps at OVS-1 -> 0; at tct=OVS-1, rxs is shifted into the shift register MSB-first-in/LSB-first-out and bct increments.
REQ-018 DATA -> STOP when the sample at tct=OVS-1 is taken with bct=DATA_BITS-1; tct is cleared.
REQ-019 STOP: at tct=OVS-1, the stop bit is sampled, rx_data is loaded right-aligned, and the FSM -> IDLE.
REQ-020 At the stop sample: rxd_readyH<=1; frame_err<=~rxs; overrun<=1 if rxd_readyH was already 1 and rxd_ack=0 that cycle, otherwise overrun holds its value.
REQ-021 Latency: rxd_readyH rises on the edge OVS/2+OVS*(DATA_BITS+1) cycles after the edge that detected the start (152 cycles at defaults).
REQ-022 rxd_ack=1 in a cycle with no stop sample SHALL clear rxd_readyH, frame_err and overrun on the next edge.
REQ-023 A simultaneous rxd_ack and stop sample: new frame flags win; rxd_readyH=1, overrun NOT set, frame_err reflects the new frame.
REQ-024 rx_data SHALL change only at the stop sample; it holds its value through subsequent frames until the next stop sample.
REQ-025 busy SHALL be a registered decode, equal to 1 in START, DATA and STOP.
REQ-026 After STOP, IDLE SHALL accept a start edge in the very next cycle (back-to-back frames with one stop bit).

Reset
REQ-027 rst_n low SHALL asynchronously force: state=IDLE, tct=0, bct=0, shift register=0, rx_data=0x00, rxd_readyH=0, frame_err=0, overrun=0, busy=0, synchronizer flops and rxs_d=1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no flag update; after release, the next frame requires a fresh start edge.

Verification
REQ-029 Send frame 0xA5 (start, 1,0,1,0,0,1,0,1 LSB first, stop=1) at 16 ticks/bit -> rx_data=0xA5, rxd_readyH=1, frame_err=0, overrun=0, 152 cycles after start detect.
REQ-030 Drive a 5-tick low glitch on rxd -> FSM returns to IDLE at the mid-start check; rxd_readyH stays 0 and rx_data is unchanged.
REQ-031 Send 0x3C with stop bit=0 -> rxd_readyH=1, frame_err=1, rx_data=0x3C; then rxd_ack -> all three flags 0.
REQ-032 Send 0x11 then 0x22 back-to-back with no ack -> rx_data=0x22, overrun=1; repeat with rxd_ack pulsed exactly at the second stop sample -> overrun=0.
REQ-033 Assert rst_n low during the DATA state of a frame -> all outputs reset values immediately; a following frame 0x5A is received correctly.
REQ-034 Hold rxd low for 3 frame times after a frame with stop=0 -> exactly one frame_err frame; no retrigger until rxd returns high and falls again.
